// File: rtl/gmii_tx_framer_if.sv
// Byte-stream handshake between the TX FIFO and the GMII framer.
// Signals: S_DATA/S_VALID/S_LAST/S_ERR from the source, S_READY back from the framer.
interface gmii_tx_framer_if;
    logic [7:0] S_DATA;
    logic       S_VALID;
    logic       S_LAST;
    logic       S_ERR;
    logic       S_READY;

    modport master (
        output S_DATA,
        output S_VALID,
        output S_LAST,
        output S_ERR,
        input  S_READY
    );

    modport slave (
        input  S_DATA,
        input  S_VALID,
        input  S_LAST,
        input  S_ERR,
        output S_READY
    );
endinterface

// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: preamble/SFD, payload, zero pad, CRC-32 FCS, IFG.
// Ports: CLK, RST_N (sync, active-low), s (stream slave), TX_D/TX_EN/TX_ERR (registered GMII).
module gmii_tx_framer #(
    parameter int MIN_PAYLOAD = 60,
    parameter int IFG_BYTES   = 12
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    gmii_tx_framer_if.slave        s,
    output logic [7:0]             TX_D,
    output logic                   TX_EN,
    output logic                   TX_ERR
);

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        SFD,
        DATA,
        PAD,
        FCS,
        DISCARD,
        IFG
    } state_t;

    localparam logic [15:0] MIN_CNT  = 16'(MIN_PAYLOAD);
    localparam logic [7:0]  IFG_LAST = 8'(IFG_BYTES - 1);

    state_t      state_q, state_d;
    logic [7:0]  cyc_q, cyc_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] crc_q, crc_d;
    logic [7:0]  tx_d_q, tx_d_d;
    logic        tx_en_q, tx_en_d;
    logic        tx_err_q, tx_err_d;

    logic        ready;
    logic [15:0] cnt_inc;
    logic [31:0] crc_base;
    logic [31:0] fcs;

    function automatic logic [31:0] crc_byte(
        input logic [31:0] c,
        input logic [7:0]  b
    );
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ b[i]) begin
                r = (r >> 1) ^ 32'hEDB8_8320;
            end else begin
                r = r >> 1;
            end
        end
        return r;
    endfunction

    // Ready depends on state only so the source never sees a
    // combinational path from its own S_VALID.
    assign ready = (state_q == SFD) ||
                   (state_q == DATA) ||
                   (state_q == DISCARD);

    assign s.S_READY = ready;

    assign cnt_inc  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    // The first payload byte is accepted while SFD is on the wire,
    // so the CRC restarts from all-ones in that cycle.
    assign crc_base = (state_q == SFD) ? 32'hFFFF_FFFF : crc_q;
    assign fcs      = ~crc_q;

    // Outputs are computed one cycle ahead and registered, so each
    // branch describes what appears on the wire next cycle.
    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        cnt_d    = cnt_q;
        crc_d    = crc_q;
        tx_d_d   = 8'h00;
        tx_en_d  = 1'b0;
        tx_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = 16'd0;
                cyc_d = 8'd0;
                if (s.S_VALID) begin
                    state_d = PREAMBLE;
                    tx_d_d  = 8'h55;
                    tx_en_d = 1'b1;
                end
            end

            PREAMBLE: begin
                tx_en_d = 1'b1;
                if (cyc_q == 8'd6) begin
                    tx_d_d  = 8'hD5;
                    cyc_d   = 8'd0;
                    state_d = SFD;
                end else begin
                    tx_d_d = 8'h55;
                    cyc_d  = cyc_q + 8'd1;
                end
            end

            SFD, DATA: begin
                tx_en_d = 1'b1;
                if (s.S_VALID) begin
                    tx_d_d   = s.S_DATA;
                    tx_err_d = s.S_ERR;
                    crc_d    = crc_byte(crc_base, s.S_DATA);
                    cnt_d    = cnt_inc;
                    if (s.S_LAST) begin
                        cyc_d   = 8'd0;
                        state_d = (cnt_inc < MIN_CNT) ? PAD : FCS;
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    // Underrun: one poisoned byte, then drop the frame.
                    tx_err_d = 1'b1;
                    state_d  = DISCARD;
                end
            end

            PAD: begin
                tx_en_d = 1'b1;
                crc_d   = crc_byte(crc_q, 8'h00);
                cnt_d   = cnt_inc;
                if (cnt_inc >= MIN_CNT) begin
                    cyc_d   = 8'd0;
                    state_d = FCS;
                end
            end

            FCS: begin
                tx_en_d = 1'b1;
                case (cyc_q[1:0])
                    2'd0:    tx_d_d = fcs[7:0];
                    2'd1:    tx_d_d = fcs[15:8];
                    2'd2:    tx_d_d = fcs[23:16];
                    default: tx_d_d = fcs[31:24];
                endcase
                if (cyc_q == 8'd3) begin
                    cyc_d   = 8'd0;
                    state_d = IFG;
                end else begin
                    cyc_d = cyc_q + 8'd1;
                end
            end

            DISCARD: begin
                if (s.S_VALID && s.S_LAST) begin
                    cyc_d   = 8'd0;
                    state_d = IFG;
                end
            end

            IFG: begin
                if (cyc_q == IFG_LAST) begin
                    cyc_d   = 8'd0;
                    state_d = IDLE;
                end else begin
                    cyc_d = cyc_q + 8'd1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            cyc_q    <= 8'd0;
            cnt_q    <= 16'd0;
            crc_q    <= 32'd0;
            tx_d_q   <= 8'h00;
            tx_en_q  <= 1'b0;
            tx_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            cnt_q    <= cnt_d;
            crc_q    <= crc_d;
            tx_d_q   <= tx_d_d;
            tx_en_q  <= tx_en_d;
            tx_err_q <= tx_err_d;
        end
    end

    assign TX_D   = tx_d_q;
    assign TX_EN  = tx_en_q;
    assign TX_ERR = tx_err_q;

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Directed/randomised bench for gmii_tx_framer against a frame-level model.
// DUT a uses default parameters; DUT b uses MIN_PAYLOAD=0.
module tb_gmii_tx_framer;

    typedef struct packed {
        logic       en;
        logic [7:0] d;
        logic       err;
    } smp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #4 clk = ~clk;

    gmii_tx_framer_if a_if ();
    gmii_tx_framer_if b_if ();

    logic [7:0] a_txd, b_txd;
    logic       a_txen, b_txen, a_txerr, b_txerr;

    gmii_tx_framer u_a (
        .CLK   (clk),
        .RST_N (rst_n),
        .s     (a_if),
        .TX_D  (a_txd),
        .TX_EN (a_txen),
        .TX_ERR(a_txerr)
    );

    gmii_tx_framer #(.MIN_PAYLOAD(0), .IFG_BYTES(12)) u_b (
        .CLK   (clk),
        .RST_N (rst_n),
        .s     (b_if),
        .TX_D  (b_txd),
        .TX_EN (b_txen),
        .TX_ERR(b_txerr)
    );

    int passes = 0;
    int total  = 0;

    smp_t cap_a[$];
    smp_t cap_b[$];
    smp_t exp_q[$];
    int   f_st[$];
    int   f_ln[$];
    int   f_gp[$];
    int   tail;
    int   zbad;
    logic [7:0] pay[$];
    logic [7:0] pay2[$];
    logic [7:0] sub[$];

    always @(negedge clk) begin
        cap_a.push_back('{en: a_txen, d: a_txd, err: a_txerr});
        cap_b.push_back('{en: b_txen, d: b_txd, err: b_txerr});
    end

    initial begin
        #200us;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic set_in(input bit sel, input logic v, input logic [7:0] d,
                          input logic l, input logic e);
        if (sel) begin
            b_if.S_VALID = v; b_if.S_DATA = d;
            b_if.S_LAST = l; b_if.S_ERR = e;
        end else begin
            a_if.S_VALID = v; a_if.S_DATA = d;
            a_if.S_LAST = l; a_if.S_ERR = e;
        end
    endtask

    // Presents p byte by byte; stall_at inserts one S_VALID=0 cycle.
    task automatic send(input bit sel, input logic [7:0] p[$],
                        input int err_idx, input int stall_at);
        bit acc;
        int n;
        for (int i = 0; i < p.size(); i++) begin
            if (i == stall_at) begin
                set_in(sel, 1'b0, 8'h00, 1'b0, 1'b0);
                @(posedge clk);
                #1;
            end
            set_in(sel, 1'b1, p[i], i == p.size() - 1, i == err_idx);
            acc = 1'b0;
            n = 0;
            while (!acc && n < 300) begin
                @(negedge clk);
                acc = sel ? b_if.S_READY : a_if.S_READY;
                @(posedge clk);
                n++;
            end
            #1;
            if (!acc) begin
                chk("handshake_timeout", 32'(acc), 32'd1);
                break;
            end
        end
        set_in(sel, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    function automatic logic [31:0] crc32(input logic [7:0] m[$]);
        logic [31:0] tbl[256];
        logic [31:0] c;
        for (int n = 0; n < 256; n++) begin
            c = 32'(n);
            for (int k = 0; k < 8; k++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
            tbl[n] = c;
        end
        c = 32'hFFFF_FFFF;
        foreach (m[i]) c = tbl[c[7:0] ^ m[i]] ^ (c >> 8);
        return c;
    endfunction

    // Expected TX_EN=1 samples of one frame.
    task automatic build(input logic [7:0] p[$], input int err_idx,
                         input int minp, input bit underrun);
        logic [7:0]  m[$];
        logic [31:0] f;
        exp_q.delete();
        for (int i = 0; i < 7; i++)
            exp_q.push_back('{en: 1'b1, d: 8'h55, err: 1'b0});
        exp_q.push_back('{en: 1'b1, d: 8'hD5, err: 1'b0});
        if (underrun) begin
            foreach (p[i]) exp_q.push_back('{en: 1'b1, d: p[i], err: 1'b0});
            exp_q.push_back('{en: 1'b1, d: 8'h00, err: 1'b1});
            return;
        end
        m = p;
        while (m.size() < minp) m.push_back(8'h00);
        foreach (m[i])
            exp_q.push_back('{en: 1'b1, d: m[i], err: (i == err_idx)});
        f = ~crc32(m);
        for (int i = 0; i < 4; i++)
            exp_q.push_back('{en: 1'b1, d: f[8*i +: 8], err: 1'b0});
    endtask

    task automatic parse(input smp_t c[$]);
        int  z;
        bit  in_f;
        z = 0;
        in_f = 0;
        zbad = 0;
        f_st.delete(); f_ln.delete(); f_gp.delete();
        for (int i = 0; i < c.size(); i++) begin
            if (c[i].en) begin
                if (!in_f) begin
                    f_st.push_back(i); f_ln.push_back(0);
                    f_gp.push_back(z); in_f = 1;
                end
                f_ln[f_ln.size() - 1]++;
                z = 0;
            end else begin
                if (c[i].d !== 8'h00 || c[i].err !== 1'b0) zbad++;
                in_f = 0;
                z++;
            end
        end
        tail = z;
    endtask

    task automatic check_frame(input string tag, input smp_t c[$],
                               input int st, input int ln);
        int n;
        chk({tag, "_len"}, 32'(ln), 32'(exp_q.size()));
        n = (ln < exp_q.size()) ? ln : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_b%0d", tag, i),
                32'({c[st+i].d, c[st+i].err}),
                32'({exp_q[i].d, exp_q[i].err}));
    endtask

    task automatic rnd(input int n);
        pay.delete();
        for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] fcs_b2;
        set_in(1'b0, 1'b1, 8'hAA, 1'b0, 1'b0);
        set_in(1'b1, 1'b1, 8'hAA, 1'b0, 1'b0);
        cyc(4);
        @(negedge clk);
        chk("rst_a_en", 32'(a_txen), 32'd0);
        chk("rst_a_d", 32'(a_txd), 32'd0);
        chk("rst_a_err", 32'(a_txerr), 32'd0);
        chk("rst_a_rdy", 32'(a_if.S_READY), 32'd0);
        chk("rst_b_en", 32'(b_txen), 32'd0);
        chk("rst_b_rdy", 32'(b_if.S_READY), 32'd0);
        set_in(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        set_in(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc(3);

        // "123456789" with no minimum payload
        pay.delete();
        for (int i = 0; i < 9; i++) pay.push_back(8'h31 + 8'(i));
        cap_b.delete();
        send(1'b1, pay, -1, -1);
        cyc(30);
        parse(cap_b);
        chk("ascii_nframes", 32'(f_st.size()), 32'd1);
        if (f_st.size() > 0) begin
            build(pay, -1, 0, 0);
            check_frame("ascii", cap_b, f_st[0], f_ln[0]);
            chk("ascii_fcs", {cap_b[f_st[0]+17].d, cap_b[f_st[0]+18].d,
                              cap_b[f_st[0]+19].d, cap_b[f_st[0]+20].d},
                32'h2639_F4CB);
        end
        chk("ascii_ifg", 32'(tail >= 12), 32'd1);
        chk("ascii_idle", 32'(zbad), 32'd0);

        // 14-byte frame padded to 60
        rnd(14);
        cap_a.delete();
        send(1'b0, pay, -1, -1);
        cyc(100);
        parse(cap_a);
        chk("pad_nframes", 32'(f_st.size()), 32'd1);
        if (f_st.size() > 0) begin
            build(pay, -1, 60, 0);
            check_frame("pad", cap_a, f_st[0], f_ln[0]);
        end
        chk("pad_idle", 32'(zbad), 32'd0);

        // two 64-byte frames back-to-back
        rnd(64);
        pay2 = pay;
        rnd(64);
        cap_a.delete();
        send(1'b0, pay2, -1, -1);
        send(1'b0, pay, -1, -1);
        cyc(120);
        parse(cap_a);
        chk("b2b_nframes", 32'(f_st.size()), 32'd2);
        if (f_st.size() == 2) begin
            build(pay2, -1, 60, 0);
            check_frame("b2b0", cap_a, f_st[0], f_ln[0]);
            chk("b2b_gap", 32'(f_gp[1]), 32'd12);
            build(pay, -1, 60, 0);
            check_frame("b2b1", cap_a, f_st[1], f_ln[1]);
        end

        // S_ERR on byte 5
        rnd(30);
        cap_a.delete();
        send(1'b0, pay, 4, -1);
        cyc(100);
        parse(cap_a);
        chk("serr_nframes", 32'(f_st.size()), 32'd1);
        if (f_st.size() > 0) begin
            build(pay, 4, 60, 0);
            check_frame("serr", cap_a, f_st[0], f_ln[0]);
        end

        // underrun after byte 20 of 40, then a short frame
        rnd(40);
        sub.delete();
        for (int i = 0; i < 20; i++) sub.push_back(pay[i]);
        cap_a.delete();
        send(1'b0, pay, -1, 20);
        rnd(5);
        send(1'b0, pay, -1, -1);
        cyc(100);
        parse(cap_a);
        chk("urun_nframes", 32'(f_st.size()), 32'd2);
        if (f_st.size() == 2) begin
            build(sub, -1, 60, 1);
            check_frame("urun", cap_a, f_st[0], f_ln[0]);
            chk("urun_gap", 32'(f_gp[1] >= 31), 32'd1);
            build(pay, -1, 60, 0);
            check_frame("urun_next", cap_a, f_st[1], f_ln[1]);
        end
        chk("urun_idle", 32'(zbad), 32'd0);

        // 1-byte frame
        rnd(1);
        cap_a.delete();
        send(1'b0, pay, -1, -1);
        cyc(100);
        parse(cap_a);
        chk("one_nframes", 32'(f_st.size()), 32'd1);
        if (f_st.size() > 0) begin
            build(pay, -1, 60, 0);
            check_frame("one", cap_a, f_st[0], f_ln[0]);
        end

        // reset during the third FCS byte
        rnd(60);
        build(pay, -1, 60, 0);
        fcs_b2 = exp_q[8 + 60 + 2].d;
        send(1'b0, pay, -1, -1);
        cyc(3);
        chk("rfcs_en", 32'(a_txen), 32'd1);
        chk("rfcs_d", 32'(a_txd), 32'(fcs_b2));
        rst_n = 1'b0;
        cyc(1);
        chk("rfcs_off_en", 32'(a_txen), 32'd0);
        chk("rfcs_off_err", 32'(a_txerr), 32'd0);
        chk("rfcs_off_d", 32'(a_txd), 32'd0);
        chk("rfcs_off_rdy", 32'(a_if.S_READY), 32'd0);
        rst_n = 1'b1;
        cyc(1);
        rnd(20);
        cap_a.delete();
        send(1'b0, pay, -1, -1);
        cyc(100);
        parse(cap_a);
        chk("post_nframes", 32'(f_st.size()), 32'd1);
        if (f_st.size() > 0) begin
            build(pay, -1, 60, 0);
            check_frame("post", cap_a, f_st[0], f_ln[0]);
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
